// File: rtl/zcmt_jvt_cache.sv
// zcmt_jvt_cache: small fully-associative cache of Zcmt jump-vector-table
// entries, placed between the Zcmt decoder's table-fetch load port and a
// dedicated data-cache load port.
//
// The decoder sees a dcache-style responder. A hit returns two cycles after
// the grant. A miss is forwarded to the data cache, filled locally and then
// returned. Every entry is invalidated on flush_i and whenever the JVT base
// changes.
//
// The load-port structs are flattened into plain ports:
//   req_*_i / req_*_o : request from / response to the Zcmt decoder
//   dc_*_o  / dc_*_i  : request to / response from the data cache
// The core-config widths appear as individual parameters.
//
// Ports:
//   clk_i, rst_i    clock; synchronous active-high reset
//   flush_i         invalidate all entries (fence.i / JVT CSR write)
//   jvt_base_i      JVT base address bits [XLEN-1:6]
//   req_data_req_i, req_address_index_i, req_address_tag_i, req_tag_valid_i,
//   req_kill_req_i, req_data_id_i, req_data_size_i, req_data_we_i
//   req_data_gnt_o, req_data_rvalid_o, req_data_rid_o, req_data_rdata_o
//   dc_data_req_o, dc_address_index_o, dc_address_tag_o, dc_tag_valid_o,
//   dc_kill_req_o, dc_data_id_o, dc_data_size_o, dc_data_we_o
//   dc_data_gnt_i, dc_data_rvalid_i, dc_data_rid_i, dc_data_rdata_i
module zcmt_jvt_cache #(
  parameter int unsigned XLEN               = 32,
  parameter int unsigned DCACHE_INDEX_WIDTH = 12,
  parameter int unsigned DCACHE_TAG_WIDTH   = 20,
  parameter int unsigned DCACHE_TID_WIDTH   = 2,
  parameter int unsigned NrEntries          = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  input  logic [XLEN-7:0]               jvt_base_i,
  // decoder side
  input  logic                          req_data_req_i,
  input  logic [DCACHE_INDEX_WIDTH-1:0] req_address_index_i,
  input  logic [DCACHE_TAG_WIDTH-1:0]   req_address_tag_i,
  input  logic                          req_tag_valid_i,
  input  logic                          req_kill_req_i,
  input  logic [DCACHE_TID_WIDTH-1:0]   req_data_id_i,
  input  logic [1:0]                    req_data_size_i,
  input  logic                          req_data_we_i,
  output logic                          req_data_gnt_o,
  output logic                          req_data_rvalid_o,
  output logic [DCACHE_TID_WIDTH-1:0]   req_data_rid_o,
  output logic [XLEN-1:0]               req_data_rdata_o,
  // data-cache side
  output logic                          dc_data_req_o,
  output logic [DCACHE_INDEX_WIDTH-1:0] dc_address_index_o,
  output logic [DCACHE_TAG_WIDTH-1:0]   dc_address_tag_o,
  output logic                          dc_tag_valid_o,
  output logic                          dc_kill_req_o,
  output logic [DCACHE_TID_WIDTH-1:0]   dc_data_id_o,
  output logic [1:0]                    dc_data_size_o,
  output logic                          dc_data_we_o,
  input  logic                          dc_data_gnt_i,
  input  logic                          dc_data_rvalid_i,
  input  logic [DCACHE_TID_WIDTH-1:0]   dc_data_rid_i,
  input  logic [XLEN-1:0]               dc_data_rdata_i
);

  localparam int unsigned KEY_W = DCACHE_TAG_WIDTH + DCACHE_INDEX_WIDTH;
  localparam int unsigned PTR_W = $clog2(NrEntries);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_TAG       = 3'd1;
  localparam logic [2:0] S_MISS_REQ  = 3'd2;
  localparam logic [2:0] S_MISS_TAG  = 3'd3;
  localparam logic [2:0] S_MISS_WAIT = 3'd4;
  localparam logic [2:0] S_RESP      = 3'd5;

  logic [2:0]                          state_q, state_d;
  logic [NrEntries-1:0]                valid_q;
  logic [NrEntries-1:0][KEY_W-1:0]     key_q;
  logic [NrEntries-1:0][XLEN-1:0]      data_q;
  logic [PTR_W-1:0]                    rr_q;
  logic [XLEN-7:0]                     base_q;
  logic [XLEN-1:0]                     rdata_q;
  logic [DCACHE_TID_WIDTH-1:0]         id_q;
  logic [DCACHE_INDEX_WIDTH-1:0]       idx_q;
  logic [DCACHE_TAG_WIDTH-1:0]         tag_q;
  logic [1:0]                          size_q;
  // An invalidation was seen while the miss was in flight, so the fetched
  // data may belong to a stale table and must not be cached.
  logic                                pend_q;

  logic                                gnt, inval, hit, rsp_match, fill;
  logic [PTR_W-1:0]                    hit_idx;
  logic [KEY_W-1:0]                    lookup_key;

  assign gnt        = (state_q == S_IDLE) & req_data_req_i & ~req_data_we_i & ~flush_i;
  assign inval      = flush_i | (jvt_base_i != base_q);
  assign lookup_key = {req_address_tag_i, idx_q};
  assign rsp_match  = (state_q == S_MISS_WAIT) & dc_data_rvalid_i & (dc_data_rid_i == id_q);
  assign fill       = rsp_match & ~pend_q & ~inval;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < int'(NrEntries); i++) begin
      if (valid_q[i] && key_q[i] == lookup_key) begin
        hit     = 1'b1;
        hit_idx = PTR_W'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (gnt) state_d = S_TAG;
      S_TAG: begin
        if (req_kill_req_i)       state_d = S_IDLE;
        else if (req_tag_valid_i) state_d = (hit && !flush_i) ? S_RESP : S_MISS_REQ;
      end
      S_MISS_REQ:  if (dc_data_gnt_i) state_d = S_MISS_TAG;
      S_MISS_TAG:  state_d = S_MISS_WAIT;
      S_MISS_WAIT: if (rsp_match) state_d = S_RESP;
      S_RESP:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      valid_q <= '0;
      key_q   <= '0;
      data_q  <= '0;
      rr_q    <= '0;
      base_q  <= '0;
      rdata_q <= '0;
      id_q    <= '0;
      idx_q   <= '0;
      tag_q   <= '0;
      size_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= jvt_base_i;
      case (state_q)
        S_IDLE: if (gnt) begin
          idx_q  <= req_address_index_i;
          id_q   <= req_data_id_i;
          size_q <= req_data_size_i;
        end
        S_TAG: if (!req_kill_req_i && req_tag_valid_i) begin
          if (hit && !flush_i) rdata_q <= data_q[hit_idx];
          else                 tag_q   <= req_address_tag_i;
          pend_q <= 1'b0;
        end
        S_MISS_REQ, S_MISS_TAG: if (inval) pend_q <= 1'b1;
        S_MISS_WAIT: begin
          if (inval)     pend_q  <= 1'b1;
          if (rsp_match) rdata_q <= dc_data_rdata_i;
        end
        default: ;
      endcase
      // Invalidation wins over a fill landing in the same cycle.
      if (inval) begin
        valid_q <= '0;
      end else if (fill) begin
        valid_q[rr_q] <= 1'b1;
        key_q[rr_q]   <= {tag_q, idx_q};
        data_q[rr_q]  <= dc_data_rdata_i;
        rr_q          <= rr_q + PTR_W'(1);
      end
    end
  end

  always_comb begin
    req_data_gnt_o     = gnt;
    req_data_rvalid_o  = 1'b0;
    req_data_rid_o     = '0;
    req_data_rdata_o   = '0;
    dc_data_req_o      = 1'b0;
    dc_address_index_o = '0;
    dc_address_tag_o   = '0;
    dc_tag_valid_o     = 1'b0;
    dc_kill_req_o      = 1'b0;
    dc_data_id_o       = '0;
    dc_data_size_o     = '0;
    dc_data_we_o       = 1'b0;
    case (state_q)
      S_MISS_REQ: begin
        dc_data_req_o      = 1'b1;
        dc_address_index_o = idx_q;
        dc_data_size_o     = size_q;
        dc_data_id_o       = id_q;
      end
      S_MISS_TAG: begin
        dc_tag_valid_o   = 1'b1;
        dc_address_tag_o = tag_q;
      end
      S_RESP: begin
        req_data_rvalid_o = 1'b1;
        req_data_rid_o    = id_q;
        req_data_rdata_o  = rdata_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_zcmt_jvt_cache.sv
// Directed + randomized bench for zcmt_jvt_cache. A small reference cache
// (address/data/valid arrays + replacement pointer) predicts hit or miss and
// the returned data; the bench plays the data cache with random latencies.
module tb_zcmt_jvt_cache;

  logic        clk = 1'b0;
  logic        rst_i, flush_i;
  logic [25:0] jvt_base_i;
  logic        req_data_req_i, req_tag_valid_i, req_kill_req_i, req_data_we_i;
  logic [11:0] req_address_index_i;
  logic [19:0] req_address_tag_i;
  logic [1:0]  req_data_id_i, req_data_size_i;
  logic        req_data_gnt_o, req_data_rvalid_o;
  logic [1:0]  req_data_rid_o;
  logic [31:0] req_data_rdata_o;
  logic        dc_data_req_o, dc_tag_valid_o, dc_kill_req_o, dc_data_we_o;
  logic [11:0] dc_address_index_o;
  logic [19:0] dc_address_tag_o;
  logic [1:0]  dc_data_id_o, dc_data_size_o;
  logic        dc_data_gnt_i, dc_data_rvalid_i;
  logic [1:0]  dc_data_rid_i;
  logic [31:0] dc_data_rdata_i;

  zcmt_jvt_cache dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .jvt_base_i(jvt_base_i),
    .req_data_req_i(req_data_req_i), .req_address_index_i(req_address_index_i),
    .req_address_tag_i(req_address_tag_i), .req_tag_valid_i(req_tag_valid_i),
    .req_kill_req_i(req_kill_req_i), .req_data_id_i(req_data_id_i),
    .req_data_size_i(req_data_size_i), .req_data_we_i(req_data_we_i),
    .req_data_gnt_o(req_data_gnt_o), .req_data_rvalid_o(req_data_rvalid_o),
    .req_data_rid_o(req_data_rid_o), .req_data_rdata_o(req_data_rdata_o),
    .dc_data_req_o(dc_data_req_o), .dc_address_index_o(dc_address_index_o),
    .dc_address_tag_o(dc_address_tag_o), .dc_tag_valid_o(dc_tag_valid_o),
    .dc_kill_req_o(dc_kill_req_o), .dc_data_id_o(dc_data_id_o),
    .dc_data_size_o(dc_data_size_o), .dc_data_we_o(dc_data_we_o),
    .dc_data_gnt_i(dc_data_gnt_i), .dc_data_rvalid_i(dc_data_rvalid_i),
    .dc_data_rid_i(dc_data_rid_i), .dc_data_rdata_i(dc_data_rdata_i)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // reference cache
  logic [31:0] m_addr [8];
  logic [31:0] m_data [8];
  bit          m_valid[8];
  int          m_rr;

  logic [31:0] pool [12];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_find(input logic [31:0] a);
    for (int i = 0; i < 8; i++) if (m_valid[i] && m_addr[i] == a) return i;
    return -1;
  endfunction

  task automatic m_inval();
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    m_inval();
    m_rr = 0;
  endtask

  task automatic flush_pulse();
    @(negedge clk); flush_i = 1'b1;
    @(negedge clk); flush_i = 1'b0;
    m_inval();
  endtask

  // mode: 0 plain, 1 flush in MISS_WAIT, 2 foreign-id rvalid in MISS_WAIT,
  //       3 reset in MISS_WAIT followed by a late matching rvalid
  task automatic do_read(input logic [31:0] addr, input logic [1:0] id, input int lat,
                         input int mode, input bit use_f, input logic [31:0] fdata);
    int          h;
    bit          supp;
    logic [31:0] d;
    h    = m_find(addr);
    supp = 1'b0;
    d    = use_f ? fdata : $urandom;
    @(negedge clk);
    req_data_req_i = 1'b1; req_data_we_i = 1'b0; req_address_index_i = addr[11:0];
    req_data_id_i = id; req_data_size_i = 2'd2;
    #1 chk("gnt_idle", req_data_gnt_o, 1);
    @(negedge clk);
    req_data_req_i = 1'b0; req_tag_valid_i = 1'b1; req_address_tag_i = addr[31:12];
    #1 chk("gnt_in_tag", req_data_gnt_o, 0);
    @(negedge clk);
    req_tag_valid_i = 1'b0;
    #1;
    if (h >= 0) begin
      chk("hit_rvalid", req_data_rvalid_o, 1);
      chk("hit_rid", req_data_rid_o, id);
      chk("hit_rdata", req_data_rdata_o, m_data[h]);
      chk("hit_no_dcreq", dc_data_req_o, 0);
    end else begin
      chk("miss_dcreq", dc_data_req_o, 1);
      chk("miss_idx", dc_address_index_o, addr[11:0]);
      chk("miss_id", dc_data_id_o, id);
      chk("miss_no_rvalid", req_data_rvalid_o, 0);
      dc_data_gnt_i = 1'b1;
      @(negedge clk);
      dc_data_gnt_i = 1'b0;
      #1 chk("miss_tagv", dc_tag_valid_o, 1);
      chk("miss_tag", dc_address_tag_o, addr[31:12]);
      for (int k = 0; k < lat; k++) begin
        @(negedge clk);
        flush_i = (mode == 1 && k == 0);
        rst_i   = (mode == 3 && k == 0);
        if (mode == 1 && k == 0) begin supp = 1'b1; m_inval(); end
        if (mode == 2 && k == 0) begin
          dc_data_rvalid_i = 1'b1; dc_data_rid_i = id + 2'd1; dc_data_rdata_i = ~d;
        end else dc_data_rvalid_i = 1'b0;
        #1 chk("wait_no_rvalid", req_data_rvalid_o, 0);
      end
      @(negedge clk);
      flush_i = 1'b0; rst_i = 1'b0;
      dc_data_rvalid_i = 1'b1; dc_data_rid_i = id; dc_data_rdata_i = d;
      @(negedge clk);
      dc_data_rvalid_i = 1'b0;
      #1;
      if (mode == 3) begin
        chk("rst_late_no_rvalid", req_data_rvalid_o, 0);
        chk("rst_state_idle", dut.state_q, 0);
        chk("rst_all_invalid", dut.valid_q, 0);
        m_inval();
        m_rr = 0;
      end else begin
        chk("miss_rvalid", req_data_rvalid_o, 1);
        chk("miss_rid", req_data_rid_o, id);
        chk("miss_rdata", req_data_rdata_o, d);
        if (!supp) begin
          m_addr[m_rr] = addr; m_data[m_rr] = d; m_valid[m_rr] = 1'b1;
          m_rr = (m_rr + 1) % 8;
        end
      end
    end
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; jvt_base_i = '0;
    req_data_req_i = 1'b0; req_tag_valid_i = 1'b0; req_kill_req_i = 1'b0; req_data_we_i = 1'b0;
    req_address_index_i = '0; req_address_tag_i = '0; req_data_id_i = '0; req_data_size_i = '0;
    dc_data_gnt_i = 1'b0; dc_data_rvalid_i = 1'b0; dc_data_rid_i = '0; dc_data_rdata_i = '0;
    for (int i = 0; i < 6; i++) begin
      pool[i]     = 32'h8000_0000 + 32'(i << 4);
      pool[i + 6] = 32'h9000_0000 + 32'(i << 4);  // same index, different tag
    end
    do_reset();

    // reset state
    #1;
    chk("rst_rvalid", req_data_rvalid_o, 0);
    chk("rst_rdata", req_data_rdata_o, 0);
    chk("rst_dcreq", dc_data_req_o, 0);
    chk("rst_dctagv", dc_tag_valid_o, 0);
    chk("rst_gnt", req_data_gnt_o, 0);
    chk("rst_state", dut.state_q, 0);
    chk("rst_valid", dut.valid_q, 0);
    chk("rst_rr", dut.rr_q, 0);

    jvt_base_i = 26'h200_0000;  // 0x8000_0000
    @(negedge clk);

    // cold miss then hit
    do_read(32'h8000_0010, 2'd1, 3, 0, 1'b1, 32'h8000_1234);
    do_read(32'h8000_0010, 2'd2, 0, 0, 1'b0, 0);

    // flush between reads, then base change
    flush_pulse();
    do_read(32'h8000_0010, 2'd3, 2, 0, 1'b0, 0);
    do_read(32'h8000_0010, 2'd0, 0, 0, 1'b0, 0);
    @(negedge clk); jvt_base_i = 26'h200_0001;  // 0x8000_0040
    m_inval();
    do_read(32'h8000_0010, 2'd1, 1, 0, 1'b0, 0);

    // fill wrap from a clean pointer
    do_reset();
    for (int i = 0; i < 9; i++) do_read(32'h8000_0100 + 32'(i << 2), 2'(i), 1, 0, 1'b0, 0);
    do_read(32'h8000_0100, 2'd0, 1, 0, 1'b0, 0);
    chk("wrap_rr", dut.rr_q, 2);
    do_read(32'h8000_0104, 2'd1, 1, 0, 1'b0, 0);
    do_read(32'h8000_0108, 2'd2, 1, 0, 1'b0, 0);

    // flush during miss: data returned, no fill
    do_read(32'h8000_0200, 2'd2, 2, 1, 1'b0, 0);
    do_read(32'h8000_0200, 2'd3, 1, 0, 1'b0, 0);
    // foreign id ignored
    do_read(32'h8000_0300, 2'd0, 3, 2, 1'b0, 0);

    // flush blocks grant in IDLE
    @(negedge clk);
    flush_i = 1'b1; req_data_req_i = 1'b1;
    #1 chk("gnt_flush", req_data_gnt_o, 0);
    @(negedge clk); flush_i = 1'b0; req_data_req_i = 1'b0;
    m_inval();

    // kill in TAG
    @(negedge clk);
    req_data_req_i = 1'b1; req_address_index_i = 12'h040;
    #1 chk("kill_gnt", req_data_gnt_o, 1);
    @(negedge clk);
    req_data_req_i = 1'b0; req_kill_req_i = 1'b1; req_tag_valid_i = 1'b1;
    req_address_tag_i = 20'h80000;
    @(negedge clk); req_kill_req_i = 1'b0; req_tag_valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk("kill_no_rvalid", req_data_rvalid_o, 0);
      chk("kill_no_dcreq", dc_data_req_o, 0);
      @(negedge clk);
    end
    // writes are never granted
    req_data_req_i = 1'b1; req_data_we_i = 1'b1;
    #1 chk("write_gnt", req_data_gnt_o, 0);
    @(negedge clk); req_data_req_i = 1'b0; req_data_we_i = 1'b0;
    #1 chk("write_state", dut.state_q, 0);

    // reset mid-miss
    do_read(32'h8000_0400, 2'd1, 2, 3, 1'b0, 0);
    do_read(32'h8000_0400, 2'd2, 1, 0, 1'b0, 0);

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      int r, mode;
      r = int'($urandom_range(0, 99));
      mode = (r < 10) ? 1 : (r < 20) ? 2 : 0;
      if ($urandom_range(0, 7) == 0) flush_pulse();
      if ($urandom_range(0, 15) == 0) begin
        @(negedge clk); jvt_base_i = jvt_base_i ^ 26'h1;
        m_inval();
      end
      do_read(pool[$urandom_range(0, 11)], 2'($urandom_range(0, 3)),
              int'($urandom_range(1, 4)), mode, 1'b0, 0);
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/zcmt_jvt_cache.md
# zcmt_jvt_cache

Small fully-associative cache of Zcmt jump-vector-table (JVT) entries. It sits between the Zcmt decoder's table-fetch load port and a dedicated data-cache load port. It answers the decoder's JVT reads as a dcache-style responder: hits return in two cycles, and misses are forwarded to the data cache, filled locally and then returned. Entries are invalidated on `flush_i` and whenever the JVT base changes.

## Interface
- `CVA6Cfg`, default `config_pkg::cva6_cfg_empty`: core configuration. Uses XLEN, DCACHE_INDEX_WIDTH, DCACHE_TAG_WIDTH and DCACHE_TID_WIDTH.
- `dcache_req_i_t`, default `logic`: load-port request struct.
- `dcache_req_o_t`, default `logic`: load-port response struct.
- `NrEntries`, default 8: number of cached entries. Must be a power of two, ≥2.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `flush_i` in 1: invalidate all entries (fence.i / JVT CSR write).
- `jvt_base_i` in XLEN-6: JVT base address bits [XLEN-1:6].
- `req_port_i` in dcache_req_i_t: request from the Zcmt decoder.
- `req_port_o` out dcache_req_o_t: response to the Zcmt decoder.
- `dcache_req_o` out dcache_req_i_t: request to the data cache.
- `dcache_resp_i` in dcache_req_o_t: response from the data cache.

## Operation
- Request fields used: `data_req`, `address_index`, `address_tag`, `tag_valid`, `kill_req`, `data_id`, `data_size`, `data_we`.
- Response fields used: `data_gnt`, `data_rvalid`, `data_rid`, `data_rdata`. All other output fields are driven to 0.
- Lookup key is the full address `{address_tag, address_index}`. Each entry holds `valid`, key and XLEN-bit data.

State machine (IDLE, TAG, MISS_REQ, MISS_TAG, MISS_WAIT, RESP):
- IDLE:
  - `req_port_o.data_gnt = data_req & ~data_we & ~flush_i`. This is combinational.
  - On grant, capture `address_index`, `data_id` and `data_size`, then go to TAG.
  - Write requests are never granted.
- TAG:
  - `kill_req` → IDLE, no response.
  - `tag_valid` with a hit and no `flush_i` → latch the entry data, go to RESP.
  - `tag_valid` with a miss, or with `flush_i` high → latch the tag, go to MISS_REQ.
  - Neither asserted → stay in TAG.
- MISS_REQ:
  - Drive `dcache_req_o.data_req=1`, captured index, `data_size`, `data_id`.
  - Advance to MISS_TAG on `dcache_resp_i.data_gnt`.
- MISS_TAG: drive `dcache_req_o.tag_valid=1` with the captured tag for exactly one cycle, then go to MISS_WAIT.
- MISS_WAIT:
  - On `dcache_resp_i.data_rvalid` with `data_rid` equal to the captured id, latch `data_rdata`.
  - Fill the entry at the round-robin pointer, advance the pointer (mod NrEntries), go to RESP.
  - The fill is suppressed if an invalidation occurred since leaving TAG. Data is still returned.
- RESP: `req_port_o.data_rvalid=1`, `data_rid` = captured id, `data_rdata` = latched data, for one cycle. Then go to IDLE.

Invalidation:
- `flush_i`, or `jvt_base_i` differing from its registered copy, clears every `valid` bit at the next edge.
- The registered copy updates every cycle.
- Invalidation takes priority over a fill in the same cycle.

## Timing
- Reset state:
  - state = IDLE, all `valid` = 0, round-robin pointer = 0.
  - Registered base = 0, latched data/id/index/tag = 0.
  - All `req_port_o` and `dcache_req_o` fields = 0, except `data_gnt`, which follows the IDLE equation.
- Reset asserted mid-miss: return to IDLE next edge, with no upstream response and no fill. An outstanding dcache response arriving afterwards is ignored.
- Hit latency: grant at cycle T, `tag_valid` at T+1, upstream `data_rvalid` at T+2.
- Miss latency, with downstream grant in the same cycle:
  - `dcache_req_o.data_req` at T+2, `tag_valid` at T+3.
  - Upstream `data_rvalid` one cycle after the matching downstream `data_rvalid`.
- One request is outstanding at a time. `data_gnt` is 0 in every state except IDLE.
- Back-to-back: a new grant is possible in the cycle after RESP.
- Downstream `data_rvalid` with a non-matching id is ignored.

## Test plan
- Cold miss then hit:
  - XLEN=32, base 0x8000_0000. Read 0x8000_0010; dcache returns 0x8000_1234 after 3 cycles → upstream rdata 0x8000_1234, rid echoed.
  - Re-read the same address → rvalid at T+2, no dcache request.
- Fill wrap: NrEntries=8, read 9 distinct addresses, then re-read the first → miss (entry 0 replaced), pointer = 2 afterwards.
- Invalidation:
  - `flush_i` pulse between two reads of the same address → second read misses.
  - Changing `jvt_base_i` to 0x8000_0040 has the same effect.
- Flush during miss: assert `flush_i` in MISS_WAIT → data still returned, entry not filled, next read of that address misses.
- Kill and write: `kill_req` in TAG → no response, no dcache traffic. A `data_we=1` request → `data_gnt` stays 0.
- Reset mid-miss: `rst_i` in MISS_WAIT, then a late dcache rvalid → no upstream rvalid, all entries invalid, state IDLE.
